l2_req_arbiter: RTL
===================

Name: l2_req_arbiter

Overview:
- Shares the single processor-side port of the unified L2 cache between the L1 instruction-side miss path (read-only) and the L1 data-side miss path (read/write).
- Round-robin arbitration, one transaction in flight at a time.
- The granted request is latched, so the L2 sees a stable address, operation and write data for the whole transaction, including multi-cycle misses and dirty write-backs.
- Per-requester saturating grant counters for performance monitoring.

Parameters:
ADDR_W, 28, line address width (matches the L2 proc_addr).
DATA_W, 128, line data width.
CNT_W, 16, width of each grant counter.

Ports:
clk  input  1  the single clock.
proc_reset_n  input  1  asynchronous, active-low reset.
i_read  input  1  I-side read request, level, held until i_ready.
i_addr  input  ADDR_W  I-side line address.
i_rdata  output  DATA_W  I-side read data, valid when i_ready=1.
i_ready  output  1  I-side completion pulse.
d_read  input  1  D-side read request.
d_write  input  1  D-side write request.
d_addr  input  ADDR_W  D-side line address.
d_wdata  input  DATA_W  D-side write line.
d_rdata  output  DATA_W  D-side read data, valid when d_ready=1.
d_ready  output  1  D-side completion pulse.
l2_read  output  1  to L2 proc_read.
l2_write  output  1  to L2 proc_write.
l2_addr  output  ADDR_W  to L2 proc_addr.
l2_wdata  output  DATA_W  to L2 proc_wdata.
l2_rdata  input  DATA_W  from L2 proc_rdata.
l2_ready  input  1  from L2 proc_ready.
cnt_i  output  CNT_W  completed I-side transactions.
cnt_d  output  CNT_W  completed D-side transactions.

Behaviour:
- Reset (proc_reset_n=0, asynchronous):
  - state=IDLE, last_grant=I, all latches 0, cnt_i=cnt_d=0.
  - All outputs 0.
  - Reset mid-transaction abandons the transaction. The L2 is reset by its own reset.
- Valid requests:
  - I-side: i_read=1.
  - D-side: d_read XOR d_write. d_read=d_write=1 is not a request and is ignored.
- States: IDLE, BUSY_I, BUSY_D.
- IDLE:
  - All l2_* outputs are 0.
  - Only one requester valid: latch its op/addr/wdata and go to its BUSY state. The I-side latch sets op=read and wdata=0.
  - Both valid: grant the side that is not last_grant. After reset the D-side wins the first tie.
  - Neither valid: stay in IDLE.
- BUSY_x:
  - l2_read, l2_write, l2_addr and l2_wdata are driven only from the latch, never from live inputs.
  - While l2_ready=0, stay in BUSY_x.
  - When l2_ready=1, in the same cycle, combinationally:
    - x_ready=1 and x_rdata=l2_rdata, only if the owner's request is still valid. Otherwise the response is dropped and both ready outputs stay 0.
  - At the following clock edge:
    - Go to IDLE and set last_grant=x.
    - Increment cnt_x, saturating at all-ones. The count increments even when the response was dropped.
- The non-owner's ready is always 0. i_rdata and d_rdata are 0 whenever the matching ready is 0.
- Latency:
  - A request seen in IDLE at cycle 0 is presented to the L2 at cycle 1.
  - An L2 hit completes at cycle 1.
  - IDLE for one cycle (cycle 2) is mandatory, so throughput is at most one transaction per 2 cycles.
  - The cycle-2 bubble lets the finished requester drop its request before re-arbitration.
- Requesters must hold a request until ready. A requester that drops early does not abort the L2 transaction: the arbiter still waits for l2_ready.
- New requests arriving during BUSY wait. No preemption.
- At most one ready pulse per grant. l2_ready in IDLE is ignored.

Test Plan:
- Reset, then i_read=1, i_addr=0x0000012, L2 hit returning 0xA5..A5 -> i_ready=1 at cycle 1 with i_rdata=0xA5..A5; state IDLE at cycle 2; cnt_i=1.
- i_read and d_write asserted together in the same cycle after reset -> D granted first (l2_write=1, l2_addr=d_addr); I granted after D completes; then with both held again, D granted next (alternation).
- D read miss, L2 holds l2_ready=0 for 20 cycles while d_addr toggles -> l2_addr stays at the latched value every cycle; d_ready=1 only in the l2_ready cycle.
- d_read=d_write=1 with i_read=0 -> no L2 access and cnt_d unchanged; then i_read=1 -> I granted.
- I request dropped after grant, before l2_ready -> i_ready stays 0, arbiter returns to IDLE after l2_ready, cnt_i increments; assert proc_reset_n=0 mid-BUSY_D -> all outputs 0 immediately and state IDLE.
- Force cnt_d to 0xFFFF via 65535 completed D transactions (or a bench preload), complete one more -> cnt_d stays 0xFFFF.

Source files
------------

// File: rtl/l2_req_arbiter.sv
// l2_req_arbiter: round-robin share of the single L2 processor port
// between the L1 I-side (read) and D-side (read/write) miss paths.
// Ports: clk, proc_reset_n (async, active-low);
//   i_read/i_addr -> i_rdata/i_ready   I-side request and response
//   d_read/d_write/d_addr/d_wdata -> d_rdata/d_ready   D-side
//   l2_read/l2_write/l2_addr/l2_wdata -> L2, l2_rdata/l2_ready <- L2
//   cnt_i/cnt_d   saturating completed-transaction counters
module l2_req_arbiter #(
  parameter int ADDR_W = 28,
  parameter int DATA_W = 128,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              proc_reset_n,
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_ready,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ready,
  output logic              l2_read,
  output logic              l2_write,
  output logic [ADDR_W-1:0] l2_addr,
  output logic [DATA_W-1:0] l2_wdata,
  input  logic [DATA_W-1:0] l2_rdata,
  input  logic              l2_ready,
  output logic [CNT_W-1:0]  cnt_i,
  output logic [CNT_W-1:0]  cnt_d
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic                last_d_q, last_d_d;
  logic                rd_q, rd_d;
  logic                wr_q, wr_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [CNT_W-1:0]    cnt_i_q, cnt_i_d;
  logic [CNT_W-1:0]    cnt_d_q, cnt_d_d;

  logic i_vld;
  logic d_vld;
  logic grant_d;

  // read+write together is not a legal D request
  assign i_vld = i_read;
  assign d_vld = d_read ^ d_write;

  // D wins a tie unless it was served last
  assign grant_d = d_vld && (!i_vld || !last_d_q);

  assign cnt_i = cnt_i_q;
  assign cnt_d = cnt_d_q;

  always_ff @(posedge clk or negedge proc_reset_n) begin
    if (!proc_reset_n) begin
      state_q  <= IDLE;
      last_d_q <= 1'b0;
      rd_q     <= 1'b0;
      wr_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      cnt_i_q  <= '0;
      cnt_d_q  <= '0;
    end else begin
      state_q  <= state_d;
      last_d_q <= last_d_d;
      rd_q     <= rd_d;
      wr_q     <= wr_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      cnt_i_q  <= cnt_i_d;
      cnt_d_q  <= cnt_d_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    last_d_d = last_d_q;
    rd_d     = rd_q;
    wr_d     = wr_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    cnt_i_d  = cnt_i_q;
    cnt_d_d  = cnt_d_q;
    i_ready  = 1'b0;
    i_rdata  = '0;
    d_ready  = 1'b0;
    d_rdata  = '0;
    l2_read  = 1'b0;
    l2_write = 1'b0;
    l2_addr  = '0;
    l2_wdata = '0;
    unique case (state_q)
      IDLE: begin
        if (grant_d) begin
          rd_d    = d_read;
          wr_d    = d_write;
          addr_d  = d_addr;
          wdata_d = d_wdata;
          state_d = BUSY_D;
        end else if (i_vld) begin
          rd_d    = 1'b1;
          wr_d    = 1'b0;
          addr_d  = i_addr;
          wdata_d = '0;
          state_d = BUSY_I;
        end
      end
      BUSY_I: begin
        l2_read  = rd_q;
        l2_write = wr_q;
        l2_addr  = addr_q;
        l2_wdata = wdata_q;
        if (l2_ready) begin
          // a requester that gave up gets no pulse
          i_ready  = i_vld;
          i_rdata  = i_vld ? l2_rdata : '0;
          state_d  = IDLE;
          last_d_d = 1'b0;
          if (!(&cnt_i_q)) begin
            cnt_i_d = cnt_i_q + CNT_W'(1);
          end
        end
      end
      BUSY_D: begin
        l2_read  = rd_q;
        l2_write = wr_q;
        l2_addr  = addr_q;
        l2_wdata = wdata_q;
        if (l2_ready) begin
          d_ready  = d_vld;
          d_rdata  = d_vld ? l2_rdata : '0;
          state_d  = IDLE;
          last_d_d = 1'b1;
          if (!(&cnt_d_q)) begin
            cnt_d_d = cnt_d_q + CNT_W'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule
